// File: rtl/custom_op_sequencer.sv
// Two-port sequencer that shares one combinational custom-ops unit.
// Requests are arbitrated, executed for one cycle, then returned over a valid/ready response.
module custom_op_sequencer #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic [1:0] op_sel_q, op_sel_d;
  logic       op_id_q, op_id_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_id_q, rsp_id_d;

  logic grant;
  logic idle;
  logic accept;

  // Under contention the port not served last wins; otherwise the lone valid port wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end
  end

  assign idle       = (state_q == IDLE);
  assign accept     = idle && (req0_valid || req1_valid);
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d       = grant ? req1_a : req0_a;
          op_b_d       = grant ? req1_b : req0_b;
          op_sel_d     = grant ? req1_sel : req0_sel;
          op_id_d      = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = op_id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      op_sel_q     <= 2'd0;
      op_id_q      <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // The custom unit sees the op registers at all times, not only during EXEC.
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_sel    = op_sel_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_custom_op_sequencer.sv
// Directed bench for custom_op_sequencer: one round-robin and one fixed-priority instance,
// each paired with a behavioural model of the custom-ops unit.
module tb_custom_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
    logic [3:0] t;
    logic [1:0] n;
    logic [2:0] inv;
    logic [3:0] o;
    int c;
    n   = b[1:0];
    inv = 3'd4 - {1'b0, n};
    o   = a | b;
    c   = 0;
    for (int i = 0; i < 4; i++) c += int'(o[i]);
    case (s)
      2'd0:    t = a << n;
      2'd1:    t = a >> n;
      2'd2:    t = (a << n) | (a >> inv);
      default: t = c[3:0];
    endcase
    return {4'b0, t};
  endfunction

  // Round-robin instance signals
  logic       r0v, r1v, r0rdy, r1rdy;
  logic [3:0] r0a, r0b, r1a, r1b;
  logic [1:0] r0s, r1s;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_result;

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  custom_op_sequencer #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy)
  );

  // Fixed-priority instance signals
  logic       f0v, f1v, f0rdy, f1rdy;
  logic [3:0] f_alu_a, f_alu_b;
  logic [1:0] f_alu_sel;
  logic [7:0] f_alu_result;
  logic       f_rsp_valid, f_rsp_ready, f_rsp_id, f_busy;
  logic [7:0] f_rsp_result;

  assign f_alu_result = alu_f(f_alu_a, f_alu_b, f_alu_sel);

  custom_op_sequencer #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f0v), .req0_ready(f0rdy), .req0_a(4'b1010), .req0_b(4'b0101), .req0_sel(2'd3),
    .req1_valid(f1v), .req1_ready(f1rdy), .req1_a(4'b0001), .req1_b(4'd3), .req1_sel(2'd0),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_sel(f_alu_sel), .alu_result(f_alu_result),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
    .rsp_result(f_rsp_result), .busy(f_busy)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    r0v = 0; r1v = 0; r0a = 0; r0b = 0; r0s = 0; r1a = 0; r1b = 0; r1s = 0;
    rsp_ready = 1'b1;
    f0v = 0; f1v = 0; f_rsp_ready = 1'b1;
    #1;
    tests++;
    if ({rsp_valid, busy, rsp_id, rsp_result, alu_a, alu_b, alu_sel, r0rdy, r1rdy} !== 23'd0) begin
      fails++;
      $display("FAIL reset_values: valid=%b busy=%b id=%b res=%h a=%h b=%h sel=%h rdy=%b%b, required all 0",
               rsp_valid, busy, rsp_id, rsp_result, alu_a, alu_b, alu_sel, r0rdy, r1rdy);
    end
    r1v = 1'b1;
    #1;
    tests++;
    if (r1rdy !== 1'b1 || r0rdy !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_rule: rdy0=%b rdy1=%b, required rdy0=0 rdy1=1", r0rdy, r1rdy);
    end
    r1v = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset checks done");
  endtask

  task automatic test_port0();
    r0v = 1; r0a = 4'b1011; r0b = 4'd2; r0s = 2'd0;
    #1;
    tests++;
    if (r0rdy !== 1'b1 || r1rdy !== 1'b0) begin
      fails++;
      $display("FAIL port0_ready: rdy0=%b rdy1=%b, required 1/0", r0rdy, r1rdy);
    end
    @(posedge clk); #1;
    r0v = 0;
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || alu_a !== 4'b1011 || alu_b !== 4'd2) begin
      fails++;
      $display("FAIL port0_exec: busy=%b valid=%b alu_a=%h alu_b=%h, required 1 0 b 2",
               busy, rsp_valid, alu_a, alu_b);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h0C || rsp_id !== 1'b0) begin
      fails++;
      $display("FAIL port0_rsp: valid=%b res=%h id=%b, required 1 0c 0", rsp_valid, rsp_result, rsp_id);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL port0_done: valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    $display("[TB] port0 shl: res=%h id=%b", 8'h0C, 1'b0);
  endtask

  task automatic test_port1();
    logic [3:0] va [2];
    logic [3:0] vb [2];
    logic [1:0] vs [2];
    logic [7:0] ve [2];
    va[0] = 4'b1001; vb[0] = 4'd1; vs[0] = 2'd2; ve[0] = 8'h03;
    va[1] = 4'b1000; vb[1] = 4'd3; vs[1] = 2'd1; ve[1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      r1v = 1; r1a = va[k]; r1b = vb[k]; r1s = vs[k];
      #1;
      tests++;
      if (r1rdy !== 1'b1 || r0rdy !== 1'b0) begin
        fails++;
        $display("FAIL port1_ready[%0d]: rdy0=%b rdy1=%b, required 0/1", k, r0rdy, r1rdy);
      end
      @(posedge clk); #1;
      r1v = 0;
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== ve[k] || rsp_id !== 1'b1) begin
        fails++;
        $display("FAIL port1_rsp[%0d]: valid=%b res=%h id=%b, required 1 %h 1",
                 k, rsp_valid, rsp_result, rsp_id, ve[k]);
      end
      @(posedge clk); #1;
      $display("[TB] port1 sel=%0d: res=%h required %h", vs[k], rsp_result, ve[k]);
    end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    logic [7:0] exp_res;
    int cnt;
    r0v = 1; r0a = 4'b1010; r0b = 4'b0101; r0s = 2'd3;
    r1v = 1; r1a = 4'b0001; r1b = 4'd3;    r1s = 2'd0;
    #1;
    tests++;
    if (r0rdy !== 1'b1 || r1rdy !== 1'b0) begin
      fails++;
      $display("FAIL rr_first_grant: rdy0=%b rdy1=%b, required 1/0", r0rdy, r1rdy);
    end
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 8'h08 : 8'h04;
      cnt = 0;
      while (rsp_valid !== 1'b1 && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      tests++;
      if (cnt >= 10) begin
        fails++;
        $display("FAIL rr_timeout[%0d]: rsp_valid=%b, required 1 within 10 cycles", k, rsp_valid);
      end else if (rsp_id !== exp_id || rsp_result !== exp_res) begin
        fails++;
        $display("FAIL rr_rsp[%0d]: id=%b res=%h, required %b %h", k, rsp_id, rsp_result, exp_id, exp_res);
      end
      $display("[TB] rr response %0d: id=%b res=%h", k, rsp_id, rsp_result);
      @(posedge clk); #1;
    end
    r0v = 0; r1v = 0;
    @(posedge clk); #1;
    // The fourth request may have been accepted in the cycle after the last response; drain it.
    while (busy === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 0;
    r0v = 1; r0a = 4'b1011; r0b = 4'd2; r0s = 2'd0;
    @(posedge clk); #1;
    r0v = 0;
    r1v = 1; r1a = 4'b0110; r1b = 4'd1; r1s = 2'd0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h0C) begin
      fails++;
      $display("FAIL bp_rsp: valid=%b res=%h, required 1 0c", rsp_valid, rsp_result);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'h0C || rsp_id !== 1'b0 || busy !== 1'b1 ||
          r0rdy !== 1'b0 || r1rdy !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b res=%h id=%b busy=%b rdy=%b%b, required 1 0c 0 1 00",
                 k, rsp_valid, rsp_result, rsp_id, busy, r0rdy, r1rdy);
      end
    end
    r1v = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    $display("[TB] backpressure held 10 cycles, released");
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    r0v = 1; r0a = 4'b1011; r0b = 4'd2; r0s = 2'd1;
    @(posedge clk); #1;
    r0v = 0;
    tests++;
    if (busy !== 1'b1 || alu_sel !== 2'd1) begin
      fails++;
      $display("FAIL rst_pre_exec: busy=%b alu_sel=%h, required 1 1", busy, alu_sel);
    end
    rst_n = 0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 4'd0 || alu_b !== 4'd0 || alu_sel !== 2'd0) begin
      fails++;
      $display("FAIL rst_async: valid=%b busy=%b a=%h b=%h sel=%h, required all 0",
               rsp_valid, busy, alu_a, alu_b, alu_sel);
    end
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rst_no_rsp: active cycles=%0d, required 0", seen);
    end
    r0v = 1; r0a = 4'b1010; r0b = 4'b0101; r0s = 2'd3;
    r1v = 1; r1a = 4'b0001; r1b = 4'd3;    r1s = 2'd0;
    #1;
    tests++;
    if (r0rdy !== 1'b1 || r1rdy !== 1'b0) begin
      fails++;
      $display("FAIL rst_first_contention: rdy0=%b rdy1=%b, required 1/0", r0rdy, r1rdy);
    end
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 8'h04) begin
      fails++;
      $display("FAIL rst_contention_rsp: valid=%b id=%b res=%h, required 1 0 04",
               rsp_valid, rsp_id, rsp_result);
    end
    @(posedge clk); #1;
    $display("[TB] reset mid-exec aborted, contention after reset id=%b", 1'b0);
  endtask

  task automatic test_operand_change();
    r0v = 1; r0a = 4'b1001; r0b = 4'd1; r0s = 2'd2;
    @(posedge clk); #1;
    r0v = 0; r0a = 4'b1111; r0b = 4'd0; r0s = 2'd3;
    tests++;
    if (alu_a !== 4'b1001 || alu_b !== 4'd1 || alu_sel !== 2'd2) begin
      fails++;
      $display("FAIL opchg_alu: a=%h b=%h sel=%h, required 9 1 2", alu_a, alu_b, alu_sel);
    end
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h03) begin
      fails++;
      $display("FAIL opchg_rsp: valid=%b res=%h, required 1 03", rsp_valid, rsp_result);
    end
    @(posedge clk); #1;
    $display("[TB] operand change after accept: res=%h", 8'h03);
  endtask

  task automatic test_fixed_priority();
    int cnt;
    f0v = 1; f1v = 1;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      while (f_rsp_valid !== 1'b1 && cnt < 10) begin
        @(posedge clk); #1;
        cnt++;
      end
      tests++;
      if (cnt >= 10) begin
        fails++;
        $display("FAIL fp_timeout[%0d]: rsp_valid=%b, required 1 within 10 cycles", k, f_rsp_valid);
      end else if (f_rsp_id !== 1'b0 || f_rsp_result !== 8'h04) begin
        fails++;
        $display("FAIL fp_rsp[%0d]: id=%b res=%h, required 0 04", k, f_rsp_id, f_rsp_result);
      end
      $display("[TB] fixed priority response %0d: id=%b res=%h", k, f_rsp_id, f_rsp_result);
      @(posedge clk); #1;
    end
    f0v = 0; f1v = 0;
  endtask

  initial begin
    test_reset();
    test_port0();
    test_port1();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_operand_change();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
